mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Memory-side responder for the eLC-3 datapath's RAM port. It accepts one read or write request at a time, addressed by MAR and carrying write data from MDR. It completes the request against an external synchronous SRAM with a fixed number of wait states, or against the memory-mapped keyboard/display registers. It returns read data to the datapath's `In` bus and pulses the ready signal `R` that the control FSM polls in its memory states.

## Interface
Parameters:
- `WAIT_STATES`, default 2: extra SRAM cycles before read data is valid. Legal range is 0–15.

Ports:
- `Clk`: input, 1 bit. System clock; all state changes on the rising edge.
- `Reset`: input, 1 bit. Asynchronous, active-high reset.
- `MAR`: input, 16 bits. Request address.
- `MDR`: input, 16 bits. Write data.
- `MIO_EN`: input, 1 bit. Request strobe, level-sensitive.
- `R_W`: input, 1 bit. 1 = write, 0 = read.
- `Data_Out`: output, 16 bits. Read data; feeds the datapath's `In`.
- `R`: output, 1 bit. Ready; a one-cycle pulse at completion of each request.
- `Sram_Addr`: output, 16 bits. SRAM address.
- `Sram_WData`: output, 16 bits. SRAM write data.
- `Sram_RData`: input, 16 bits. SRAM read data.
- `Sram_CE`: output, 1 bit. SRAM chip enable, active-high.
- `Sram_WE`: output, 1 bit. SRAM write enable, active-high.
- `Kbd_Data`: input, 8 bits. Keyboard character.
- `Kbd_Valid`: input, 1 bit. Keyboard character present.
- `Kbd_Ready`: output, 1 bit. Responder can accept a character.
- `Disp_Data`: output, 8 bits. Display character.
- `Disp_Valid`: output, 1 bit. Display character pending.
- `Disp_Ready`: input, 1 bit. Display consumed the character.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - When `MIO_EN`=1, latch `MAR`, `MDR` and `R_W`.
  - SRAM address → ACCESS with the wait counter set to `WAIT_STATES`.
  - I/O address → DONE.
- ACCESS:
  - Drives `Sram_CE`=1, `Sram_Addr` = latched address, `Sram_WData` = latched data, `Sram_WE` = latched `R_W`.
  - Counter decrements each cycle.
  - When the counter reaches 0: a read captures `Sram_RData` into `Data_Out`, then → DONE.
- DONE:
  - `R`=1 for exactly this cycle, then → IDLE.
  - Side effects of I/O accesses take effect on the DONE→IDLE edge.
- Requester handshake: the requester must drop `MIO_EN` in the cycle after `R`. Any `MIO_EN`=1 sampled in IDLE is a new request.
- `MIO_EN` changes in ACCESS/DONE are ignored; the latched request completes.
- I/O map:
  - KBSR 0xFE00: read {KBSR15, 15'b0}.
  - KBDR 0xFE02: read {8'h00, KBDR}; clears KBSR15.
  - DSR 0xFE04: read {DSR15, 15'b0}.
  - DDR 0xFE06: write loads `Disp_Data` = MDR[7:0], sets `Disp_Valid`, clears DSR15. The write is ignored if DSR15=0.
  - Writes to KBSR, KBDR and DSR are ignored. Reads of DDR return 0.
  - Other addresses in 0xFE00–0xFFFF go to SRAM.
- Keyboard:
  - `Kbd_Ready` = ~KBSR15.
  - `Kbd_Valid` & `Kbd_Ready` loads KBDR = `Kbd_Data` and sets KBSR15.
  - A character offered while KBSR15=1 is not accepted; the source holds it.
- Display:
  - `Disp_Valid` & `Disp_Ready` clears `Disp_Valid` and sets DSR15.
- Writes never change `Data_Out`. `Data_Out` holds the last read value.

## Timing
- Reset (asynchronous) values:
  - FSM = IDLE.
  - `R`, `Sram_CE`, `Sram_WE`, `Disp_Valid` = 0.
  - `Data_Out`, `Sram_Addr`, `Sram_WData`, `Disp_Data` = 0.
  - KBSR15=0 (so `Kbd_Ready`=1); KBDR=0.
  - DSR15=1.
- Reset mid-access abandons the access; no SRAM write continues after `Reset` rises.
- SRAM latency: request sampled at edge 0. ACCESS occupies cycles 1..`WAIT_STATES`+1. `R` is high in cycle `WAIT_STATES`+2. `Data_Out` is valid in the same cycle as `R`.
- I/O latency: `R` is high in cycle 1.
- `R` and all outputs are registered; there are no combinational paths from inputs to outputs except `Kbd_Ready`, which is derived from state only.
- A KBDR read completing while `Kbd_Valid`=1 cannot collide, because `Kbd_Ready`=0 until the clear. A new character is accepted in the cycle after DONE at the earliest.
- A DDR write and `Disp_Ready` in the same DONE cycle cannot collide: the write is accepted only if DSR15=1, which implies `Disp_Valid`=0.

## Configuration
- `ELC3_MMIO_EN` defined:
  - I/O decode and keyboard/display registers are present as above.
- `ELC3_MMIO_EN` not defined:
  - All addresses go to SRAM.
  - `Kbd_Ready`=0, `Disp_Valid`=0, `Disp_Data`=0 constant.
  - The keyboard/display inputs are ignored.

## Test plan
- Reset, `WAIT_STATES`=2, write 0x1234 to 0x3000 → `Sram_CE`=`Sram_WE`=1 for 3 cycles at addr 0x3000 with data 0x1234; `R` in cycle 4; `Data_Out` stays 0x0000.
- SRAM model returns 0xBEEF for addr 0x3000, read 0x3000 → `R` in cycle 4 with `Data_Out`=0xBEEF; `Sram_WE`=0 throughout.
- `Kbd_Valid`=1 with `Kbd_Data`=0x41 → `Kbd_Ready` falls next cycle. Read 0xFE00 → 0x8000 with `R` in cycle 1. Read 0xFE02 → 0x0041. Read 0xFE00 → 0x0000 and `Kbd_Ready`=1.
- Write 0x0058 to 0xFE06 → `Disp_Valid`=1, `Disp_Data`=0x58, and read 0xFE04 → 0x0000. Second write of 0x0059 → ignored. `Disp_Ready` pulse → `Disp_Valid`=0 and read 0xFE04 → 0x8000.
- `Reset` asserted in the second ACCESS cycle of a write → `Sram_CE`/`Sram_WE`/`R` low immediately; the next request completes normally.
- `ELC3_MMIO_EN` undefined, read 0xFE00 → SRAM access with `R` in cycle 4; `Kbd_Ready`=0.

Source files
------------

// File: rtl/mem_io_responder.sv
// mem_io_responder
// Memory-side responder for the eLC-3 RAM port. Serves one request at a time:
// SRAM accesses run through a fixed number of wait states, while keyboard and
// display register accesses complete in a single cycle. R pulses for one cycle
// when each request completes.
//
// Optional feature macro: ELC3_MMIO_EN
//   defined   -> KBSR/KBDR/DSR/DDR registers are decoded at 0xFE00..0xFE06
//   undefined -> every address goes to SRAM and the keyboard/display ports are idle
module mem_io_responder #(
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        MIO_EN,
  input  logic        R_W,
  output logic [15:0] Data_Out,
  output logic        R,
  output logic [15:0] Sram_Addr,
  output logic [15:0] Sram_WData,
  input  logic [15:0] Sram_RData,
  output logic        Sram_CE,
  output logic        Sram_WE,
  input  logic [7:0]  Kbd_Data,
  input  logic        Kbd_Valid,
  output logic        Kbd_Ready,
  output logic [7:0]  Disp_Data,
  output logic        Disp_Valid,
  input  logic        Disp_Ready
);

  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  wait_cnt;
  logic        req_write;
  logic        start_sram;
  logic        start_io;
  logic        access_last;
  logic        io_hit;
  logic [15:0] io_rdata;

  // Next-state and per-cycle control decode
  always_comb begin
    next_state  = state;
    start_sram  = 1'b0;
    start_io    = 1'b0;
    access_last = 1'b0;
    case (state)
      IDLE: begin
        if (MIO_EN) begin
          if (io_hit) begin
            start_io   = 1'b1;
            next_state = DONE;
          end else begin
            start_sram = 1'b1;
            next_state = ACCESS;
          end
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          access_last = 1'b1;
          next_state  = DONE;
        end else begin
          next_state  = ACCESS;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Wait-state counter: loaded on an SRAM request, counts down through ACCESS
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= 4'd0;
    end else if (start_sram) begin
      wait_cnt <= WAIT_LOAD;
    end else if ((state == ACCESS) && !access_last) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Remember the direction of the request being served
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      req_write <= 1'b0;
    end else if ((state == IDLE) && MIO_EN) begin
      req_write <= R_W;
    end
  end

  // SRAM port: load address/data/direction on entry to ACCESS, release on exit
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Sram_CE    <= 1'b0;
      Sram_WE    <= 1'b0;
      Sram_Addr  <= 16'h0000;
      Sram_WData <= 16'h0000;
    end else if (start_sram) begin
      Sram_CE    <= 1'b1;
      Sram_WE    <= R_W;
      Sram_Addr  <= MAR;
      Sram_WData <= MDR;
    end else if (access_last) begin
      Sram_CE    <= 1'b0;
      Sram_WE    <= 1'b0;
    end
  end

  // Ready pulse: high exactly for the DONE cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      R <= 1'b0;
    end else begin
      R <= (next_state == DONE);
    end
  end

  // Read data: register reads load on acceptance, SRAM reads on the last wait
  // state, so the value is present alongside R. Writes leave it untouched.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Data_Out <= 16'h0000;
    end else if (start_io && !R_W) begin
      Data_Out <= io_rdata;
    end else if (access_last && !req_write) begin
      Data_Out <= Sram_RData;
    end
  end

`ifdef ELC3_MMIO_EN
  logic        kbsr15;
  logic [7:0]  kbdr;
  logic        dsr15;
  logic        io_active;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic        kbdr_read_done;
  logic        ddr_write_done;

  // DSR ready and a pending display character are mutually exclusive
  assign dsr15     = ~Disp_Valid;
  assign Kbd_Ready = ~kbsr15;

  assign io_hit = (MAR == KBSR_ADDR) || (MAR == KBDR_ADDR) ||
                  (MAR == DSR_ADDR)  || (MAR == DDR_ADDR);

  // Register read multiplexer, evaluated against the incoming address
  always_comb begin
    io_rdata = 16'h0000;
    case (MAR)
      KBSR_ADDR: io_rdata = {kbsr15, 15'd0};
      KBDR_ADDR: io_rdata = {8'h00, kbdr};
      DSR_ADDR:  io_rdata = {dsr15, 15'd0};
      default:   io_rdata = 16'h0000;
    endcase
  end

  // Capture register-access address/data; io_active marks its DONE cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      io_active <= 1'b0;
      io_addr   <= 16'h0000;
      io_wdata  <= 8'h00;
    end else if (start_io) begin
      io_active <= 1'b1;
      io_addr   <= MAR;
      io_wdata  <= MDR[7:0];
    end else begin
      io_active <= 1'b0;
    end
  end

  // Side effects are applied on the DONE->IDLE edge
  assign kbdr_read_done = io_active && !req_write && (io_addr == KBDR_ADDR);
  assign ddr_write_done = io_active &&  req_write && (io_addr == DDR_ADDR);

  // Keyboard status/data: accept a character only while the status is clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      kbsr15 <= 1'b0;
      kbdr   <= 8'h00;
    end else if (Kbd_Valid && !kbsr15) begin
      kbsr15 <= 1'b1;
      kbdr   <= Kbd_Data;
    end else if (kbdr_read_done) begin
      kbsr15 <= 1'b0;
    end
  end

  // Display data: a DDR write is taken only when the display is ready
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Disp_Valid <= 1'b0;
      Disp_Data  <= 8'h00;
    end else if (ddr_write_done && dsr15) begin
      Disp_Valid <= 1'b1;
      Disp_Data  <= io_wdata;
    end else if (Disp_Valid && Disp_Ready) begin
      Disp_Valid <= 1'b0;
    end
  end
`else
  logic unused_mmio_inputs;

  assign io_hit     = 1'b0;
  assign io_rdata   = 16'h0000;
  assign Kbd_Ready  = 1'b0;
  assign Disp_Valid = 1'b0;
  assign Disp_Data  = 8'h00;
  assign unused_mmio_inputs = ^{Kbd_Data, Kbd_Valid, Disp_Ready};
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder
// Scoreboard bench: requests push expected completions into a queue, and an
// independent monitor checks each R pulse and every SRAM-enabled cycle.
// Works with ELC3_MMIO_EN either defined or undefined.
module tb_mem_io_responder;

  localparam int W = 2;
`ifdef ELC3_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        Clk;
  logic        Reset;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] Data_Out;
  logic        R;
  logic [15:0] Sram_Addr;
  logic [15:0] Sram_WData;
  logic [15:0] Sram_RData;
  logic        Sram_CE;
  logic        Sram_WE;
  logic [7:0]  Kbd_Data;
  logic        Kbd_Valid;
  logic        Kbd_Ready;
  logic [7:0]  Disp_Data;
  logic        Disp_Valid;
  logic        Disp_Ready;

  mem_io_responder #(.WAIT_STATES(W)) dut (
    .Clk(Clk), .Reset(Reset), .MAR(MAR), .MDR(MDR), .MIO_EN(MIO_EN), .R_W(R_W),
    .Data_Out(Data_Out), .R(R), .Sram_Addr(Sram_Addr), .Sram_WData(Sram_WData),
    .Sram_RData(Sram_RData), .Sram_CE(Sram_CE), .Sram_WE(Sram_WE),
    .Kbd_Data(Kbd_Data), .Kbd_Valid(Kbd_Valid), .Kbd_Ready(Kbd_Ready),
    .Disp_Data(Disp_Data), .Disp_Valid(Disp_Valid), .Disp_Ready(Disp_Ready)
  );

  typedef struct {
    logic [15:0] dout;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    int          ce;
    int          we;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          done_cnt = 0;
  int          ce_cnt  = 0;
  int          we_cnt  = 0;
  int          ce_streak;

  // SRAM contents: device side and reference side are kept separately
  logic [15:0] dev_mem [int];
  logic [15:0] ref_mem [int];

  // Reference model of the register block
  logic        m_kbsr15;
  logic [7:0]  m_kbdr;
  logic        m_dsr15;
  logic        m_disp_valid;
  logic [7:0]  m_disp_data;
  logic [15:0] m_dout;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    forever begin
      @(posedge Clk);
      cyc = cyc + 1;
    end
  end

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] dev_read(input logic [15:0] a);
    if (dev_mem.exists(int'(a))) return dev_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic exp_kbd_ready();
    return MMIO ? ~m_kbsr15 : 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  // SRAM device: data is only valid in the final wait-state cycle
  initial begin
    ce_streak  = 0;
    Sram_RData = 16'h0000;
    forever begin
      @(negedge Clk);
      if (Reset || !Sram_CE) begin
        ce_streak  = 0;
        Sram_RData = 16'hDEAD;
      end else begin
        if (Sram_WE) dev_mem[int'(Sram_Addr)] = Sram_WData;
        else if (ce_streak == W) Sram_RData = dev_read(Sram_Addr);
        else Sram_RData = 16'hDEAD;
        ce_streak++;
      end
    end
  end

  // Monitor: checks SRAM port cycles and every completion against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        ce_cnt = 0;
        we_cnt = 0;
      end else begin
        if (Sram_CE) begin
          ce_cnt++;
          if (Sram_WE) we_cnt++;
          if (exp_q.size() > 0) begin
            chk("sram_addr", Sram_Addr, exp_q[0].addr);
            if (Sram_WE) chk("sram_wdata", Sram_WData, exp_q[0].wdata);
          end
        end
        if (R) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_r", R, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("data_out", Data_Out, e.dout);
            chk("r_latency", cyc - e.issue, e.lat);
            chk("ce_cycles", ce_cnt, e.ce);
            chk("we_cycles", we_cnt, e.we);
          end
          ce_cnt = 0;
          we_cnt = 0;
          done_cnt++;
        end
      end
    end
  end

  // Issue one request, predict its outcome, wait (bounded) for completion
  task automatic issue(input logic [15:0] addr, input logic [15:0] data, input logic wr);
    exp_t e;
    logic io;
    int   start;
    io = MMIO && ((addr == 16'hFE00) || (addr == 16'hFE02) ||
                  (addr == 16'hFE04) || (addr == 16'hFE06));
    e.addr  = addr;
    e.wdata = data;
    if (io) begin
      e.lat = 1; e.ce = 0; e.we = 0;
      if (wr) begin
        if ((addr == 16'hFE06) && m_dsr15) begin
          m_disp_data  = data[7:0];
          m_disp_valid = 1'b1;
          m_dsr15      = 1'b0;
        end
      end else begin
        case (addr)
          16'hFE00: m_dout = {m_kbsr15, 15'd0};
          16'hFE02: begin m_dout = {8'h00, m_kbdr}; m_kbsr15 = 1'b0; end
          16'hFE04: m_dout = {m_dsr15, 15'd0};
          default:  m_dout = 16'h0000;
        endcase
      end
    end else begin
      e.lat = W + 2; e.ce = W + 1; e.we = wr ? W + 1 : 0;
      if (wr) ref_mem[int'(addr)] = data;
      else m_dout = ref_read(addr);
    end
    e.dout = m_dout;
    @(negedge Clk);
    MAR = addr; MDR = data; R_W = wr; MIO_EN = 1'b1;
    e.issue = cyc;
    start = done_cnt;
    exp_q.push_back(e);
    @(negedge Clk);
    MIO_EN = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (done_cnt != start) break;
      @(negedge Clk);
    end
    if (done_cnt == start) begin
      n_total++;
      n_fail++;
      $display("FAIL r_timeout: no R for addr %h within 40 cycles", addr);
      finish_run();
    end
    @(posedge Clk);
    #1;
    chk("disp_valid", Disp_Valid, m_disp_valid);
    chk("disp_data", Disp_Data, m_disp_data);
    chk("kbd_ready", Kbd_Ready, exp_kbd_ready());
  endtask

  task automatic kbd_offer(input logic [7:0] ch);
    @(negedge Clk);
    Kbd_Data = ch; Kbd_Valid = 1'b1;
    if (MMIO && !m_kbsr15) begin
      m_kbsr15 = 1'b1;
      m_kbdr   = ch;
    end
    @(posedge Clk);
    #1;
    Kbd_Valid = 1'b0;
    chk("kbd_ready_offer", Kbd_Ready, exp_kbd_ready());
  endtask

  task automatic disp_ack();
    @(negedge Clk);
    Disp_Ready = 1'b1;
    if (m_disp_valid) begin
      m_disp_valid = 1'b0;
      m_dsr15      = 1'b1;
    end
    @(posedge Clk);
    #1;
    Disp_Ready = 1'b0;
    chk("disp_valid_ack", Disp_Valid, m_disp_valid);
    chk("disp_data_ack", Disp_Data, m_disp_data);
  endtask

  task automatic model_reset();
    m_kbsr15 = 1'b0; m_kbdr = 8'h00; m_dsr15 = 1'b1;
    m_disp_valid = 1'b0; m_disp_data = 8'h00; m_dout = 16'h0000;
  endtask

  logic [15:0] pool [12];

  initial begin
    Reset = 1'b1; MAR = 16'h0000; MDR = 16'h0000; MIO_EN = 1'b0; R_W = 1'b0;
    Kbd_Data = 8'h00; Kbd_Valid = 1'b0; Disp_Ready = 1'b0;
    model_reset();
    dev_mem[int'(16'h3000)] = 16'hBEEF;
    ref_mem[int'(16'h3000)] = 16'hBEEF;
    for (int i = 0; i < 6; i++) pool[i] = 16'h3000 + 16'(i);
    pool[6] = 16'hFE00; pool[7] = 16'hFE02; pool[8] = 16'hFE04;
    pool[9] = 16'hFE06; pool[10] = 16'hFE08; pool[11] = 16'hFFFF;

    repeat (3) @(negedge Clk);
    chk("rst_r", R, 1'b0);
    chk("rst_ce", Sram_CE, 1'b0);
    chk("rst_we", Sram_WE, 1'b0);
    chk("rst_data_out", Data_Out, 16'h0000);
    chk("rst_sram_addr", Sram_Addr, 16'h0000);
    chk("rst_sram_wdata", Sram_WData, 16'h0000);
    chk("rst_disp_valid", Disp_Valid, 1'b0);
    chk("rst_disp_data", Disp_Data, 8'h00);
    chk("rst_kbd_ready", Kbd_Ready, exp_kbd_ready());
    Reset = 1'b0;

    // SRAM read of a preloaded word, write, read back
    issue(16'h3000, 16'h0000, 1'b0);
    issue(16'h3000, 16'h1234, 1'b1);
    issue(16'h3000, 16'h0000, 1'b0);

    // Keyboard path
    kbd_offer(8'h41);
    issue(16'hFE00, 16'h0000, 1'b0);
    kbd_offer(8'h42);
    issue(16'hFE02, 16'h0000, 1'b0);
    issue(16'hFE00, 16'h0000, 1'b0);

    // Display path
    issue(16'hFE06, 16'h0058, 1'b1);
    issue(16'hFE04, 16'h0000, 1'b0);
    issue(16'hFE06, 16'h0059, 1'b1);
    issue(16'hFE06, 16'h0000, 1'b0);
    disp_ack();
    issue(16'hFE04, 16'h0000, 1'b0);

    // Reset in the second ACCESS cycle of a write abandons it at once
    @(negedge Clk);
    MAR = 16'h4444; MDR = 16'hCAFE; R_W = 1'b1; MIO_EN = 1'b1;
    @(negedge Clk);
    MIO_EN = 1'b0;
    @(negedge Clk);
    chk("abort_ce_before", Sram_CE, 1'b1);
    Reset = 1'b1;
    #1;
    chk("abort_ce", Sram_CE, 1'b0);
    chk("abort_we", Sram_WE, 1'b0);
    chk("abort_r", R, 1'b0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    ce_cnt = 0;
    we_cnt = 0;
    chk("abort_data_out", Data_Out, 16'h0000);
    chk("abort_kbd_ready", Kbd_Ready, exp_kbd_ready());
    issue(16'h3001, 16'h0000, 1'b0);
    issue(16'h3001, 16'hA5A5, 1'b1);

    // Randomised mix of requests and keyboard/display traffic
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op == 0) kbd_offer(8'($urandom_range(0, 255)));
      else if (op == 1) disp_ack();
      else issue(pool[$urandom_range(0, 11)], 16'($urandom), ($urandom_range(0, 9) < 4));
    end

    repeat (3) @(negedge Clk);
    chk("queue_drained", exp_q.size(), 0);
    finish_run();
  end

endmodule
